// File: rtl/vga_cfg_axil_arbiter.sv
// Two-requester arbiter in front of the VGA controller's AXI4-Lite register bank.
// Serialises one write or read at a time; round-robin or fixed-priority grant, one-cycle response pulse.
module vga_cfg_axil_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter bit FAIR       = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    grant_id, last_grant;
    logic                    aw_done, w_done;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;

    logic                    sel_id;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    aw_hs, w_hs;

    // On a conflict the fair arbiter hands the grant to whoever did not win last time.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        sel_id = 1'b0;
        if (req_valid == 2'b11)
            sel_id = FAIR ? ~last_grant : 1'b0;
        else if (req_valid == 2'b10)
            sel_id = 1'b1;
    end

    assign sel_addr  = sel_id ? req_addr[2*ADDR_WIDTH-1 -: ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    assign sel_wdata = sel_id ? req_wdata[2*DATA_WIDTH-1 -: DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
            resp_q     <= 2'b00;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id   <= sel_id;
                        last_grant <= sel_id;
                        lat_addr   <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
                        lat_wdata  <= sel_wdata;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                    end
                end
                WR_AW_W: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                WR_B: begin
                    if (m_axi_bvalid) begin
                        resp_q  <= m_axi_bresp;
                        rdata_q <= '0;
                    end
                end
                RD_R: begin
                    if (m_axi_rvalid) begin
                        resp_q  <= m_axi_rresp;
                        rdata_q <= m_axi_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid) state_nxt = req_write[sel_id] ? WR_AW_W : RD_AR;
            WR_AW_W: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_B;
            WR_B:    if (m_axi_bvalid) state_nxt = RESP;
            RD_AR:   if (m_axi_arready) state_nxt = RD_R;
            RD_R:    if (m_axi_rvalid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // req_ready is gated by reset because the state register already reads IDLE while reset is held.
    assign req_ready     = (state == IDLE && |req_valid && !reset) ? {sel_id, ~sel_id} : 2'b00;
    assign rsp_valid     = (state == RESP) ? {grant_id, ~grant_id} : 2'b00;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;

    assign m_axi_awaddr  = lat_addr;
    assign m_axi_araddr  = lat_addr;
    assign m_axi_wdata   = lat_wdata;
    assign m_axi_awvalid = (state == WR_AW_W) && !aw_done;
    assign m_axi_wvalid  = (state == WR_AW_W) && !w_done;
    assign m_axi_bready  = (state == WR_B);
    assign m_axi_arvalid = (state == RD_AR);
    assign m_axi_rready  = (state == RD_R);

endmodule

// File: tb/tb_vga_cfg_axil_arbiter.sv
// Bench for vga_cfg_axil_arbiter: AXI4-Lite slave model with stall knobs, scoreboard of expected responses,
// and a second fixed-priority instance for the non-fair grant order.
`timescale 1ns/1ps
module tb_vga_cfg_axil_arbiter;
    localparam int AW = 4;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [1:0]      req_valid, req_write, req_ready, rsp_valid, rsp_resp;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
    logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
    logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic            m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic            m_axi_rvalid, m_axi_rready;
    logic [1:0]      m_axi_bresp, m_axi_rresp;

    vga_cfg_axil_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FAIR(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    // Fixed-priority instance with an always-ready slave.
    logic [1:0]      fp_req_valid, fp_req_ready, fp_rsp_valid, fp_rsp_resp;
    logic [DW-1:0]   fp_rsp_rdata, fp_wdata;
    logic [AW-1:0]   fp_awaddr, fp_araddr;
    logic            fp_awvalid, fp_wvalid, fp_bready, fp_arvalid, fp_rready;
    logic            fp_bvalid, fp_rvalid;

    vga_cfg_axil_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FAIR(1'b0)) dut_fp (
        .clock(clock), .reset(reset),
        .req_valid(fp_req_valid), .req_write(2'b00), .req_addr(8'h84), .req_wdata('0),
        .req_ready(fp_req_ready), .rsp_valid(fp_rsp_valid), .rsp_rdata(fp_rsp_rdata), .rsp_resp(fp_rsp_resp),
        .m_axi_awaddr(fp_awaddr), .m_axi_awvalid(fp_awvalid), .m_axi_awready(1'b1),
        .m_axi_wdata(fp_wdata), .m_axi_wvalid(fp_wvalid), .m_axi_wready(1'b1),
        .m_axi_bresp(2'b00), .m_axi_bvalid(fp_bvalid), .m_axi_bready(fp_bready),
        .m_axi_araddr(fp_araddr), .m_axi_arvalid(fp_arvalid), .m_axi_arready(1'b1),
        .m_axi_rdata(32'h0), .m_axi_rresp(2'b00), .m_axi_rvalid(fp_rvalid),
        .m_axi_rready(fp_rready)
    );

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            fp_bvalid <= 1'b0;
            fp_rvalid <= 1'b0;
        end else begin
            if (fp_awvalid && fp_wvalid) fp_bvalid <= 1'b1;
            else if (fp_bready)          fp_bvalid <= 1'b0;
            if (fp_arvalid)              fp_rvalid <= 1'b1;
            else if (fp_rready)          fp_rvalid <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model: ready after a programmable number of stalled valid cycles; rvalid after r_wait cycles.
    int         aw_wait = 0, w_wait = 0, r_wait = 0;
    logic [1:0] bresp_cfg = 2'b00;
    int         aw_cnt, w_cnt, r_cnt;
    int         n_aw = 0, n_w = 0, n_b = 0;
    logic       aw_got, w_got, ar_pend, s_bvalid, s_rvalid;
    logic [1:0] s_bresp;
    logic [AW-1:0] s_awaddr, s_araddr, s_wr_addr;
    logic [DW-1:0] s_wdata, s_rdata, s_wr_data;
    logic [DW-1:0] s_mem [4];
    logic       s_aw_hs, s_w_hs, s_ar_hs;

    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_wait);
    assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_wait);
    assign m_axi_arready = m_axi_arvalid;
    assign m_axi_bvalid  = s_bvalid;
    assign m_axi_bresp   = s_bresp;
    assign m_axi_rvalid  = s_rvalid;
    assign m_axi_rdata   = s_rdata;
    assign m_axi_rresp   = 2'b00;
    assign s_aw_hs   = m_axi_awvalid && m_axi_awready;
    assign s_w_hs    = m_axi_wvalid && m_axi_wready;
    assign s_ar_hs   = m_axi_arvalid && m_axi_arready;
    assign s_wr_addr = s_aw_hs ? m_axi_awaddr : s_awaddr;
    assign s_wr_data = s_w_hs ? m_axi_wdata : s_wdata;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_pend <= 1'b0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rdata <= '0;
            s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0;
            for (int i = 0; i < 4; i++) s_mem[i] <= '0;
        end else begin
            if (m_axi_awvalid && !m_axi_awready) aw_cnt <= aw_cnt + 1;
            if (m_axi_wvalid && !m_axi_wready)   w_cnt  <= w_cnt + 1;
            if (s_aw_hs) begin aw_cnt <= 0; aw_got <= 1'b1; s_awaddr <= m_axi_awaddr; n_aw <= n_aw + 1; end
            if (s_w_hs)  begin w_cnt <= 0;  w_got <= 1'b1;  s_wdata <= m_axi_wdata;   n_w <= n_w + 1;   end
            if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
                s_mem[s_wr_addr[3:2]] <= s_wr_data;
                s_bvalid <= 1'b1;
                s_bresp  <= bresp_cfg;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end
            if (s_bvalid && m_axi_bready) begin s_bvalid <= 1'b0; n_b <= n_b + 1; end
            if (s_ar_hs) begin
                if (r_wait == 0) begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= s_mem[m_axi_araddr[3:2]];
                end else begin
                    ar_pend  <= 1'b1;
                    s_araddr <= m_axi_araddr;
                    r_cnt    <= 1;
                end
            end
            if (ar_pend) begin
                if (r_cnt >= r_wait) begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= s_mem[s_araddr[3:2]];
                    ar_pend  <= 1'b0;
                end else r_cnt <= r_cnt + 1;
            end
            if (s_rvalid && m_axi_rready) s_rvalid <= 1'b0;
        end
    end

    // Scoreboard: an entry is pushed when a grant is seen and popped on rsp_valid.
    typedef struct {
        logic          id;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        int            t;
    } exp_t;

    exp_t          sb [$];
    int            grants [$];
    logic [DW-1:0] mdl_mem [4];
    logic          mdl_last = 1'b1;
    logic          mdl_busy = 1'b0;
    bit            chk_lat  = 1'b0;
    int            cycle    = 0;
    int            rsp_seen = 0;

    function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        if (v == 2'b10) return 2'b10;
        if (v == 2'b01) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        int   id;
        if (reset) begin
            mdl_busy = 1'b0;
            mdl_last = 1'b1;
            sb.delete();
            for (int i = 0; i < 4; i++) mdl_mem[i] = '0;
        end else begin
            cycle++;
            if (!mdl_busy) begin
                if (req_valid != 2'b00 || req_ready != 2'b00)
                    check("req_ready", req_ready, exp_grant(req_valid, mdl_last));
                if (req_ready != 2'b00) begin
                    id      = req_ready[1] ? 1 : 0;
                    e.id    = req_ready[1];
                    e.wr    = req_write[id];
                    e.addr  = req_addr[AW*id +: AW];
                    e.wdata = req_wdata[DW*id +: DW];
                    e.rdata = e.wr ? '0 : mdl_mem[e.addr[3:2]];
                    e.resp  = e.wr ? bresp_cfg : 2'b00;
                    e.t     = cycle;
                    if (e.wr) mdl_mem[e.addr[3:2]] = e.wdata;
                    sb.push_back(e);
                    grants.push_back(id);
                    mdl_busy = 1'b1;
                    mdl_last = e.id;
                end
            end else if (req_ready != 2'b00) begin
                check("req_ready_busy", req_ready, 2'b00);
            end
            if (s_aw_hs) begin
                if (sb.size() == 0) check("aw_no_txn", 1'b1, 1'b0);
                else check("awaddr", m_axi_awaddr, {sb[0].addr[AW-1:2], 2'b00});
            end
            if (s_w_hs) begin
                if (sb.size() == 0) check("w_no_txn", 1'b1, 1'b0);
                else check("wdata", m_axi_wdata, sb[0].wdata);
            end
            if (s_ar_hs) begin
                if (sb.size() == 0) check("ar_no_txn", 1'b1, 1'b0);
                else check("araddr", m_axi_araddr, {sb[0].addr[AW-1:2], 2'b00});
            end
            if (rsp_valid != 2'b00) begin
                rsp_seen++;
                if (sb.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 2'b00);
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid", rsp_valid, e.id ? 2'b10 : 2'b01);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_resp", rsp_resp, e.resp);
                    if (chk_lat) check("rsp_latency", cycle - e.t, 3);
                    mdl_busy = 1'b0;
                end
            end
        end
    end

    int fp_grants = 0;
    always @(negedge clock) begin
        if (!reset && fp_req_ready != 2'b00) begin
            check("fp_grant", fp_req_ready, 2'b01);
            fp_grants++;
        end
    end

    task automatic drive_req(input int id, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(posedge clock); #1;
        req_write[id]          = wr;
        req_addr[AW*id +: AW]  = addr;
        req_wdata[DW*id +: DW] = data;
        req_valid[id]          = 1'b1;
    endtask

    task automatic wait_ready(input int id);
        int n = 0;
        do begin @(negedge clock); n++; end while (!req_ready[id] && n < 100);
        check("ready_timeout", req_ready[id], 1'b1);
        @(posedge clock); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mdl_busy || sb.size() != 0) && n < 200) begin @(posedge clock); n++; end
        check("idle_timeout", mdl_busy, 1'b0);
    endtask

    task automatic do_txn(input int id, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        drive_req(id, wr, addr, data);
        wait_ready(id);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, a0, w0, b0, r0;
        reset = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        fp_req_valid = '0;
        repeat (2) @(negedge clock);
        check("reset_ctrl", {req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                             m_axi_arvalid, m_axi_rready}, '0);
        check("reset_data", {rsp_rdata, rsp_resp, m_axi_awaddr, m_axi_araddr}, '0);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("idle_quiet", {req_ready, rsp_valid, m_axi_awvalid, m_axi_arvalid}, '0);

        // Minimum-latency write then read-back by the other requester.
        chk_lat = 1'b1;
        do_txn(0, 1'b1, 4'h4, 32'h0000_0002);
        do_txn(1, 1'b0, 4'h4, 32'h0);
        do_txn(1, 1'b0, 4'h7, 32'h0);

        // Both requesters held: round-robin alternation over 8 grants.
        base = grants.size();
        @(posedge clock); #1;
        req_write = 2'b01;
        req_addr  = {4'h8, 4'h8};
        req_wdata = {32'h0, 32'hA5A5_1234};
        req_valid = 2'b11;
        n = 0;
        while (grants.size() < base + 8 && n < 300) begin @(posedge clock); n++; end
        #1 req_valid = 2'b00;
        wait_idle();
        check("rr_grant_count", grants.size() - base, 8);
        for (int i = 0; i < 8; i++) check("rr_order", grants[base + i], i % 2);

        // Fixed-priority instance: req0 wins every time.
        @(posedge clock); #1 fp_req_valid = 2'b11;
        n = 0;
        while (fp_grants < 8 && n < 300) begin @(posedge clock); n++; end
        #1 fp_req_valid = 2'b00;
        repeat (5) @(posedge clock);
        check("fp_grant_count", fp_grants, 8);

        // AW accepted at once, W stalled until the fifth cycle after grant.
        chk_lat = 1'b0;
        w_wait  = 4;
        a0 = n_aw; w0 = n_w; b0 = n_b; r0 = rsp_seen;
        drive_req(0, 1'b1, 4'hC, 32'h0000_0055);
        wait_ready(0);
        @(negedge clock);
        check("split_c1", {m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready}, 4'b1110);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clock);
            check("split_stall", {m_axi_awvalid, m_axi_wvalid, m_axi_wready}, 3'b010);
        end
        @(negedge clock);
        check("split_c5", {m_axi_awvalid, m_axi_wvalid, m_axi_wready}, 3'b011);
        wait_idle();
        check("split_counts", {n_aw - a0, n_w - w0, n_b - b0, rsp_seen - r0}, {32'd1, 32'd1, 32'd1, 32'd1} >> 64);
        check("split_aw_w", {n_aw - a0, n_w - w0}, {32'd1, 32'd1});
        check("split_b_rsp", {n_b - b0, rsp_seen - r0}, {32'd1, 32'd1});
        do_txn(1, 1'b0, 4'hC, 32'h0);

        // Slave error on one write, then a clean write.
        w_wait    = 0;
        chk_lat   = 1'b1;
        bresp_cfg = 2'b10;
        do_txn(1, 1'b1, 4'h0, 32'h0000_1234);
        bresp_cfg = 2'b00;
        do_txn(0, 1'b1, 4'h0, 32'h0000_5678);

        // Reset while the read waits for rvalid: everything drops, no response.
        chk_lat = 1'b0;
        r_wait  = 20;
        drive_req(0, 1'b0, 4'h4, 32'h0);
        wait_ready(0);
        repeat (3) @(negedge clock);
        check("in_rd_r", m_axi_rready, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_ctrl", {req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                 m_axi_arvalid, m_axi_rready}, '0);
        check("async_rst_data", {rsp_rdata, rsp_resp, m_axi_awaddr, m_axi_araddr}, '0);
        @(negedge clock);
        @(posedge clock); #1 reset = 1'b0;
        r_wait = 0;
        r0 = rsp_seen;
        repeat (6) @(posedge clock);
        check("no_rsp_after_rst", rsp_seen - r0, 0);

        chk_lat = 1'b1;
        base = grants.size();
        @(posedge clock); #1;
        req_write = 2'b10;
        req_addr  = {4'h8, 4'h4};
        req_wdata = {32'h0000_00EE, 32'h0};
        req_valid = 2'b11;
        wait_ready(0);
        wait_ready(1);
        wait_idle();
        check("post_rst_first", grants[base], 0);
        check("post_rst_second", grants[base + 1], 1);
        do_txn(1, 1'b0, 4'h8, 32'h0);

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
